// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-requester RAM arbiter.
package ram_arbiter_pkg;

  // CLEAR is only reachable when RAM_ARBITER_CLEAR_EN is defined.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Requester index, also used as the last-granted pointer.
  typedef logic req_idx_t;

  localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/ram_2nxm.sv
// Single-port RAM, 2**N x M: registered write, combinational read.
module ram_2nxm #(
  parameter int N = 6,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         we,
  input  logic [N-1:0] adr,
  input  logic [M-1:0] din,
  output logic [M-1:0] dout
);

  logic [M-1:0] mem [2**N];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[adr] <= din;
  end

  assign dout = mem[adr];

endmodule

// File: rtl/ram_arbiter_rr.sv
// Two-way round-robin grant: a lone valid wins; on contention the
// requester not granted last wins. No grant while disabled.
module ram_arbiter_rr
  import ram_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  req_idx_t           ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  // One-hot grant from the valid pair and last-granted pointer.
  always_comb begin
    grant = '0;
    if (enable) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester controller for a single-port RAM (registered write,
// combinational read). Round-robin arbitration with a same-cycle
// valid/ready handshake; read data is registered into a one-cycle
// response pulse per requester.
// Optional: RAM_ARBITER_CLEAR_EN builds a CLEAR state that zeroes the
// whole array after reset before any request is accepted.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int N = 6,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_we,
  input  logic [N-1:0] req0_adr,
  input  logic [M-1:0] req0_wdata,
  output logic         rsp0_valid,
  output logic [M-1:0] rsp0_rdata,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_we,
  input  logic [N-1:0] req1_adr,
  input  logic [M-1:0] req1_wdata,
  output logic         rsp1_valid,
  output logic [M-1:0] rsp1_rdata,
  output logic         ram_we,
  output logic [N-1:0] ram_adr,
  output logic [M-1:0] ram_din,
  input  logic [M-1:0] ram_dout,
  output logic         busy
);

  state_t state_q, state_d;
  req_idx_t ptr_q, ptr_d;

  logic [NUM_REQ-1:0]        req_valid, req_we, grant;
  logic [NUM_REQ-1:0][N-1:0] req_adr;
  logic [NUM_REQ-1:0][M-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][M-1:0] rsp_rdata_q, rsp_rdata_d;

  logic         run_en;
  logic         clr_act;
  logic [N-1:0] clr_adr;

  assign req_valid = {req1_valid, req0_valid};
  assign req_we    = {req1_we,    req0_we};
  assign req_adr   = {req1_adr,   req0_adr};
  assign req_wdata = {req1_wdata, req0_wdata};

  // Gating with rst_n keeps every output at its reset value while reset
  // is held, even though the FSM state itself already reads RUN/CLEAR.
  assign run_en = (state_q == RUN) && rst_n;

  ram_arbiter_rr u_rr (
    .valid  (req_valid),
    .ptr    (ptr_q),
    .enable (run_en),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

`ifdef RAM_ARBITER_CLEAR_EN
  localparam logic [N:0] CLR_LAST = {1'b0, {N{1'b1}}};

  logic [N:0] clr_cnt_q, clr_cnt_d;

  // Walk every address once, then hand over to RUN on terminal count.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + (N+1)'(1);
      if (clr_cnt_q == CLR_LAST) state_d = RUN;
    end
  end

  // State and clear counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign clr_act = (state_q == CLEAR) && rst_n;
  assign clr_adr = clr_cnt_q[N-1:0];
  assign busy    = (state_q == CLEAR);
`else
  // Without the clear feature the block lives in RUN permanently.
  always_comb begin
    state_d = RUN;
  end

  // State register (constant RUN in this build).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign clr_act = 1'b0;
  assign clr_adr = '0;
  assign busy    = 1'b0;
`endif

  // RAM port mux: clear walk has priority, else the granted requester.
  always_comb begin
    ram_we  = 1'b0;
    ram_adr = '0;
    ram_din = '0;
    if (clr_act) begin
      ram_we  = 1'b1;
      ram_adr = clr_adr;
    end else if (grant[0]) begin
      ram_we  = req_we[0];
      ram_adr = req_adr[0];
      ram_din = req_wdata[0];
    end else if (grant[1]) begin
      ram_we  = req_we[1];
      ram_adr = req_adr[1];
      ram_din = req_wdata[1];
    end
  end

  // Last-granted pointer follows every transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (grant[0])      ptr_d = 1'b0;
    else if (grant[1]) ptr_d = 1'b1;
  end

  // Reads capture ram_dout at the accepting edge; data holds otherwise.
  always_comb begin
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = grant[i] & ~req_we[i];
      if (rsp_valid_d[i]) rsp_rdata_d[i] = ram_dout;
    end
  end

  // Pointer and response registers; pointer resets to 1 so req0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 1'b1;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rsp_rdata_q[0];
  assign rsp1_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a ram_2nxm model.
// Adapts to builds with and without RAM_ARBITER_CLEAR_EN.
module tb_ram_arbiter;
  localparam int N = 6;
  localparam int M = 32;
`ifdef RAM_ARBITER_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req0_ready, req0_we, rsp0_valid;
  logic req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [N-1:0] req0_adr, req1_adr, ram_adr;
  logic [M-1:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata;
  logic [M-1:0] ram_din, ram_dout;
  logic ram_we, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_adr(req0_adr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_adr(req1_adr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  ram_2nxm #(.N(N), .M(M)) u_ram (
    .clk(clk), .we(ram_we), .adr(ram_adr), .din(ram_din), .dout(ram_dout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_we = 1'b0; req0_adr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_adr = '0; req1_wdata = '0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

`ifdef RAM_ARBITER_CLEAR_EN
  // Called at posedge+1 right after reset release; returns at posedge+1 in RUN.
  task automatic run_clear();
    for (int k = 0; k < 2**N; k++) begin
      req0_valid = (k < 10);
      @(negedge clk);
      chk("clr_busy", busy, 1'b1);
      chk("clr_we", ram_we, 1'b1);
      chk("clr_adr", ram_adr, k);
      chk("clr_din", ram_din, 0);
      if (k == 0) chk("clr_rdy0", req0_ready, 1'b0);
      next_cyc();
    end
    chk("clr_done_busy", busy, 1'b0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 1'b0;
    req0_valid = 1'b1;  // read of address 0 presented across reset release
    #12;
    @(negedge clk);
    chk("rst_busy", busy, BUSY_RST);
    chk("rst_rdy0", req0_ready, 1'b0);
    chk("rst_rsp0v", rsp0_valid, 1'b0);
    chk("rst_rsp0d", rsp0_rdata, 0);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_adr", ram_adr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef RAM_ARBITER_CLEAR_EN
    req0_valid = 1'b0;
    run_clear();
    // Cleared array reads back zero.
    req0_valid = 1'b1; req0_adr = 6'd5;
    @(negedge clk); chk("clr_rd_rdy0", req0_ready, 1'b1);
    next_cyc(); idle();
    @(negedge clk);
    chk("clr_rd_v", rsp0_valid, 1'b1);
    chk("clr_rd_d", rsp0_rdata, 0);
    next_cyc();
`else
    @(negedge clk);
    chk("nc_busy", busy, 1'b0);
    chk("nc_rdy0", req0_ready, 1'b1);
    next_cyc(); idle();
    @(negedge clk);
    chk("nc_rsp0v", rsp0_valid, 1'b1);
    next_cyc();
`endif

    // Write then read back the same address from req0.
    req0_valid = 1'b1; req0_we = 1'b1; req0_adr = 6'd3; req0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_rdy0", req0_ready, 1'b1);
    chk("wr_we", ram_we, 1'b1);
    chk("wr_adr", ram_adr, 3);
    chk("wr_din", ram_din, 32'hDEADBEEF);
    next_cyc();
    req0_we = 1'b0; req0_wdata = '0;
    @(negedge clk);
    chk("rd_rdy0", req0_ready, 1'b1);
    chk("rd_we", ram_we, 1'b0);
    chk("wr_no_rsp", rsp0_valid, 1'b0);
    next_cyc(); idle();
    @(negedge clk);
    chk("rd_rsp0v", rsp0_valid, 1'b1);
    chk("rd_rsp0d", rsp0_rdata, 32'hDEADBEEF);
    chk("rd_rsp1v", rsp1_valid, 1'b0);
    next_cyc();
    @(negedge clk);
    chk("rd_pulse_end", rsp0_valid, 1'b0);
    chk("rd_hold", rsp0_rdata, 32'hDEADBEEF);
    next_cyc();

    // Reset asserted while a read response is pending.
    req0_valid = 1'b1; req0_adr = 6'd3;
    @(negedge clk); chk("mr_rdy0", req0_ready, 1'b1);
    next_cyc();
    chk("mr_pending", rsp0_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_rsp0v", rsp0_valid, 1'b0);
    chk("mr_rsp0d", rsp0_rdata, 0);
    chk("mr_rdy0", req0_ready, 1'b0);
    chk("mr_we", ram_we, 1'b0);
    chk("mr_busy", busy, BUSY_RST);
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef RAM_ARBITER_CLEAR_EN
    run_clear();
`endif

    // Continuous contention right after reset: 0,1,0,1,0,1.
    req0_valid = 1'b1; req0_adr = 6'd20;
    req1_valid = 1'b1; req1_adr = 6'd21;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("ct_rdy0", req0_ready, (c % 2) == 0);
      chk("ct_rdy1", req1_ready, (c % 2) == 1);
      chk("ct_adr", ram_adr, (c % 2) ? 21 : 20);
      chk("ct_rsp0v", rsp0_valid, (c > 0) && ((c - 1) % 2 == 0));
      chk("ct_rsp1v", rsp1_valid, (c > 0) && ((c - 1) % 2 == 1));
      next_cyc();
    end
    idle();
    @(negedge clk);
    chk("ct_last_rsp1", rsp1_valid, 1'b1);
    chk("ct_last_rsp0", rsp0_valid, 1'b0);
    next_cyc();

    // Preload 10..13 with their own address via req0.
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_we = 1'b1; req0_adr = 6'(10 + k); req0_wdata = 32'(10 + k);
      @(negedge clk);
      chk("pl_rdy0", req0_ready, 1'b1);
      if (k > 0) chk("pl_no_rsp", rsp0_valid, 1'b0);
      next_cyc();
    end
    idle();

    // req1 back-to-back reads of 10..13.
    for (int k = 0; k < 4; k++) begin
      req1_valid = 1'b1; req1_adr = 6'(10 + k);
      @(negedge clk);
      chk("b2b_rdy1", req1_ready, 1'b1);
      chk("b2b_adr", ram_adr, 10 + k);
      chk("b2b_rsp1v", rsp1_valid, k > 0);
      if (k > 0) chk("b2b_rsp1d", rsp1_rdata, 10 + k - 1);
      next_cyc();
    end
    idle();
    @(negedge clk);
    chk("b2b_last_v", rsp1_valid, 1'b1);
    chk("b2b_last_d", rsp1_rdata, 13);
    next_cyc();
    @(negedge clk);
    chk("b2b_end_v", rsp1_valid, 1'b0);
    chk("b2b_hold_d", rsp1_rdata, 13);
    chk("b2b_rsp0v", rsp0_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
